pmod_da4_rx: RTL and testbench
==============================

# pmod_da4_rx

SPI responder that decodes the 32-bit PmodDA4 (AD5628-style) frames driven on `sck`/`sdi`/`sync_n` and presents each completed write as an AXI-Stream beat of command, address and data. It is the receiving end of the DAC link. It serves as a loopback/checker target for the DAC transmitter in simulation and on hardware, where the transmitter pins can be wired back into FPGA inputs. It oversamples the asynchronous SPI pins with the system clock; no SPI clock domain exists inside the block.

## Interface
- `DATA_W`, 12: DAC data field width. Legal values 12..16.
- `FIFO_DEPTH`, 2: output buffer depth, in frames. Must be a power of two, at least 2.
- `clk` in 1: system clock, 50 MHz.
- `rst` in 1: reset. One clock; reset is synchronous and active-high.
- `sck` in 1: SPI clock from the transmitter. Asynchronous to `clk`.
- `sdi` in 1: SPI data, MSB first.
- `sync_n` in 1: frame select, active low.
- `m_axis_tdata` out 8+DATA_W: `{cmd[3:0], addr[3:0], data[DATA_W-1:0]}`.
- `m_axis_tvalid` out 1: output beat valid.
- `m_axis_tready` in 1: downstream accept.
- `frame_err` out 1: one-cycle pulse when a frame is aborted.
- `drop` out 1: one-cycle pulse when a completed frame is lost because the buffer is full.
- `busy` out 1: high while a frame is in progress.
- `frame_cnt` out 16: completed frames. Present only with `PMOD_DA4_RX_STATS_EN`.
- `err_cnt` out 16: aborted frames plus dropped frames. Present only with `PMOD_DA4_RX_STATS_EN`.

## Operation
**Input conditioning**
- `sck`, `sdi` and `sync_n` each pass through a 2-flop synchronizer followed by one edge-detect register.
- Detected events: `sck` falling edge, `sync_n` falling edge, `sync_n` rising edge.
- `sdi` is sampled from its synchronized value at the synchronized `sck` falling edge.

**Frame format** (bit 31 is shifted first)
- `[31:28]`: don't care.
- `[27:24]`: `cmd`.
- `[23:20]`: `addr`.
- `[19:20-DATA_W]`: `data`.
- Remaining low bits: don't care.

**State machine**
- `ARM`: entered from reset. Waits for the synchronized `sync_n` to be high, then moves to `IDLE`. This prevents decoding a partial frame after reset.
- `IDLE`: on a `sync_n` falling edge, clear `bit_cnt` and go to `SHIFT`.
- `SHIFT`: each `sck` falling edge shifts one bit into a 32-bit register and increments `bit_cnt`.
  - On the 32nd bit, the frame completes: push it to the FIFO and go to `HOLD`.
  - If `sync_n` rises while `bit_cnt` < 32, pulse `frame_err`, discard the frame and go to `IDLE`.
  - If a `sync_n` rise and the 32nd `sck` fall arrive in the same cycle, the frame completes and no `frame_err` is raised.
- `HOLD`: further `sck` edges are ignored. A `sync_n` rising edge returns the FSM to `IDLE`.

**Output buffer**
- FIFO depth is `FIFO_DEPTH`, first-word fall-through.
- A beat transfers when `m_axis_tvalid && m_axis_tready`.
- A push and a pop in the same cycle are both honored, even when the FIFO is full.
- A push while full (and not popping): the new frame is discarded, `drop` pulses, and stored frames are kept.

**Other outputs**
- `busy` = state is `SHIFT` or `HOLD`.

**Reset values**
- `m_axis_tvalid`=0, `m_axis_tdata`=0, `frame_err`=0, `drop`=0, `busy`=0, counters=0.
- FIFO is emptied. Synchronizer stages reset to `sync_n`=1, `sck`=0, `sdi`=0.
- Reset asserted mid-frame abandons the frame silently: no `frame_err`, no output.

## Timing
- Supported `sck` ≤ `clk`/4 (12.5 MHz at 50 MHz). Each `sck` high and low phase must be at least 2 `clk` cycles.
- `sdi` must be stable for at least 2 `clk` cycles around each `sck` falling edge.
- Pin-to-event latency is 3 `clk` cycles: 2 synchronizer flops plus 1 edge register.
- The 32nd `sck` fall reaches the pin; 4 cycles later `m_axis_tvalid` is high (empty FIFO).
- `frame_err` asserts 4 cycles after the aborting `sync_n` pin rise.
- `drop` asserts on the same cycle a push would have occurred.
- `m_axis_tdata` is stable while `m_axis_tvalid` is high and `m_axis_tready` is low.
- `frame_err` and `drop` are each exactly 1 cycle wide.

## Configuration
- `PMOD_DA4_RX_STATS_EN` defined:
  - `frame_cnt` increments on each completed frame, including dropped ones.
  - `err_cnt` increments on each `frame_err` or `drop` pulse; simultaneous events add 2.
  - Both counters wrap at 16 bits and reset to 0.
- Undefined: both ports and their counter logic are absent. All other behaviour is identical.

## Structure
- Package `pmod_da4_pkg` holds:
  - frame length constant `DA4_FRAME_BITS`=32;
  - field positions `CMD_MSB`=27 and `ADDR_MSB`=23, and data MSB=19;
  - command codes: `WR_IN`=4'h0, `UPD`=4'h1, `WR_UPD_ALL`=4'h2, `WR_UPD`=4'h3, `PWR`=4'h4, `REF`=4'h8;
  - the state enum (`ARM`, `IDLE`, `SHIFT`, `HOLD`).
- One sub-module, `pmod_da4_rx_sync`: a per-pin 2-flop synchronizer plus edge detector with `rise`/`fall` outputs. It is instantiated 3 times.
- The FIFO stays inline.

## Test plan
- Reset, then frame 0x032ABC00 at 5 MHz with `DATA_W`=12 and `tready`=1 -> one beat `tdata`=0x32ABC, no `frame_err`.
- `sync_n` raised after 20 bits -> `frame_err` pulses once, no `tvalid`. A following full frame 0x0170FFF0 -> `tdata`=0x170FF.
- `tready`=0 while three frames are sent (data 0x001, 0x002, 0x003) -> `drop` pulses on the third. Then `tready`=1 -> beats 0x001 then 0x002, then `tvalid`=0.
- `rst` pulsed after 10 bits with `sync_n` held low; the remaining 22 bits are sent, then `sync_n` rises -> no beat, no `frame_err`. The next full frame is decoded normally.
- 36 `sck` falls within one `sync_n` low period on frame 0x0F5A5A5A -> a single beat `tdata`=0xF5A5A. The extra bits are ignored.
- With `PMOD_DA4_RX_STATS_EN`: 3 good frames, 1 aborted, 1 dropped -> `frame_cnt`=4, `err_cnt`=2.

Source files
------------

// File: rtl/pmod_da4_pkg.sv
// pmod_da4_pkg: shared constants, command codes and FSM states
// for the PmodDA4 SPI frame receiver.
package pmod_da4_pkg;

    localparam int DA4_FRAME_BITS = 32;
    localparam int CMD_MSB        = 27;
    localparam int ADDR_MSB       = 23;
    localparam int DATA_MSB       = 19;

    localparam logic [3:0] WR_IN      = 4'h0;
    localparam logic [3:0] UPD        = 4'h1;
    localparam logic [3:0] WR_UPD_ALL = 4'h2;
    localparam logic [3:0] WR_UPD     = 4'h3;
    localparam logic [3:0] PWR        = 4'h4;
    localparam logic [3:0] REF        = 4'h8;

    typedef enum logic [1:0] {
        ARM   = 2'd0,
        IDLE  = 2'd1,
        SHIFT = 2'd2,
        HOLD  = 2'd3
    } rx_state_e;

endpackage

// File: rtl/pmod_da4_rx_sync.sv
// pmod_da4_rx_sync: 2-flop synchronizer for one async pin plus a
// registered edge detector; level and edge strobes are time-aligned.
module pmod_da4_rx_sync
    import pmod_da4_pkg::*;
#(
    parameter logic RST_VAL = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_pin,
    output logic o_level,
    output logic o_rise,
    output logic o_fall
);

    logic r_meta;
    logic r_sync;
    logic r_prev;
    logic r_rise;
    logic r_fall;

    // synchronize the pin, keep a delayed copy, register its edges
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
            r_prev <= RST_VAL;
            r_rise <= 1'b0;
            r_fall <= 1'b0;
        end else begin
            r_meta <= i_pin;
            r_sync <= r_meta;
            r_prev <= r_sync;
            r_rise <= r_sync & ~r_prev;
            r_fall <= ~r_sync & r_prev;
        end
    end

    assign o_level = r_prev;
    assign o_rise  = r_rise;
    assign o_fall  = r_fall;

endmodule

// File: rtl/pmod_da4_rx.sv
// pmod_da4_rx: oversampling SPI responder for PmodDA4 frames, output
// as AXI-Stream beats. Optional counters: PMOD_DA4_RX_STATS_EN.
module pmod_da4_rx
    import pmod_da4_pkg::*;
#(
    parameter int DATA_W     = 12,
    parameter int FIFO_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sck,
    input  logic              sdi,
    input  logic              sync_n,
    output logic [8+DATA_W-1:0] m_axis_tdata,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic              frame_err,
    output logic              drop,
`ifdef PMOD_DA4_RX_STATS_EN
    output logic              busy,
    output logic [15:0]       frame_cnt,
    output logic [15:0]       err_cnt
`else
    output logic              busy
`endif
);

    localparam int BEAT_W  = 8 + DATA_W;
    localparam int PTR_W   = $clog2(FIFO_DEPTH);
    localparam int SHIFT_W = CMD_MSB;

    logic w_sck_fall;
    logic w_sck_rise_unused;
    logic w_sck_lvl_unused;
    logic w_sdi;
    logic w_sdi_rise_unused;
    logic w_sdi_fall_unused;
    logic w_sync_lvl;
    logic w_sync_rise;
    logic w_sync_fall;

    pmod_da4_rx_sync #(.RST_VAL(1'b0)) u_sync_sck (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_pin   (sck),
        .o_level (w_sck_lvl_unused),
        .o_rise  (w_sck_rise_unused),
        .o_fall  (w_sck_fall)
    );

    pmod_da4_rx_sync #(.RST_VAL(1'b0)) u_sync_sdi (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_pin   (sdi),
        .o_level (w_sdi),
        .o_rise  (w_sdi_rise_unused),
        .o_fall  (w_sdi_fall_unused)
    );

    pmod_da4_rx_sync #(.RST_VAL(1'b1)) u_sync_cs (
        .i_clk   (clk),
        .i_rst   (rst),
        .i_pin   (sync_n),
        .o_level (w_sync_lvl),
        .o_rise  (w_sync_rise),
        .o_fall  (w_sync_fall)
    );

    rx_state_e          r_state;
    logic [1:0]         r_arm_cnt;
    logic [4:0]         r_bit_cnt;
    logic [SHIFT_W-1:0] r_shift;
    logic               r_err;
    logic               r_drop;
    logic               w_last;
    logic               w_push;
    logic [BEAT_W-1:0]  w_beat;

    // Only frame bits 27..1 are kept: higher bits fall off the top and
    // the final bit is never part of the beat.
    assign w_last = w_sck_fall &&
                    (r_bit_cnt == 5'(DA4_FRAME_BITS - 1));
    assign w_push = (r_state == SHIFT) && w_last;
    assign w_beat = r_shift[SHIFT_W-1 -: BEAT_W];
    assign busy   = (r_state == SHIFT) || (r_state == HOLD);

    // Frame FSM. ARM waits until sync_n has read high for 4 samples so
    // the reset value of the synchronizer cannot fake an idle line.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ARM;
            r_arm_cnt <= 2'd0;
            r_bit_cnt <= 5'd0;
            r_shift   <= '0;
            r_err     <= 1'b0;
        end else begin
            r_err <= 1'b0;
            unique case (r_state)
                ARM: begin
                    if (!w_sync_lvl)
                        r_arm_cnt <= 2'd0;
                    else if (r_arm_cnt == 2'd3)
                        r_state <= IDLE;
                    else
                        r_arm_cnt <= r_arm_cnt + 2'd1;
                end
                IDLE: begin
                    if (w_sync_fall) begin
                        r_bit_cnt <= 5'd0;
                        r_state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    if (w_sck_fall) begin
                        r_shift   <= {r_shift[SHIFT_W-2:0], w_sdi};
                        r_bit_cnt <= r_bit_cnt + 5'd1;
                    end
                    // a rise coinciding with the last bit already
                    // closed the frame, so skip HOLD
                    if (w_last) begin
                        r_state <= w_sync_rise ? IDLE : HOLD;
                    end else if (w_sync_rise) begin
                        r_err   <= 1'b1;
                        r_state <= IDLE;
                    end
                end
                HOLD: begin
                    if (w_sync_rise)
                        r_state <= IDLE;
                end
            endcase
        end
    end

    assign frame_err = r_err;
    assign drop      = r_drop;

    logic [BEAT_W-1:0] r_mem [FIFO_DEPTH];
    logic [PTR_W:0]    r_wptr;
    logic [PTR_W:0]    r_rptr;
    logic [PTR_W:0]    w_count;
    logic              w_empty;
    logic              w_full;
    logic              w_pop;
    logic              w_wr;

    assign w_count = r_wptr - r_rptr;
    assign w_empty = (w_count == '0);
    assign w_full  = (w_count == (PTR_W+1)'(FIFO_DEPTH));
    assign w_pop   = m_axis_tvalid && m_axis_tready;
    assign w_wr    = w_push && (!w_full || w_pop);

    assign m_axis_tvalid = !w_empty;
    assign m_axis_tdata  = w_empty ? '0 : r_mem[r_rptr[PTR_W-1:0]];

    // FIFO pointers and the drop strobe for pushes into a full buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
            r_drop <= 1'b0;
        end else begin
            if (w_wr)
                r_wptr <= r_wptr + 1'b1;
            if (w_pop)
                r_rptr <= r_rptr + 1'b1;
            r_drop <= w_push && w_full && !w_pop;
        end
    end

    // FIFO storage; contents are masked by tvalid so need no reset
    always_ff @(posedge clk) begin
        if (w_wr)
            r_mem[r_wptr[PTR_W-1:0]] <= w_beat;
    end

`ifdef PMOD_DA4_RX_STATS_EN
    logic [15:0] r_frame_cnt;
    logic [15:0] r_err_cnt;

    // completed frames (dropped ones too) and error pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_cnt <= '0;
            r_err_cnt   <= '0;
        end else begin
            if (w_push)
                r_frame_cnt <= r_frame_cnt + 16'd1;
            r_err_cnt <= r_err_cnt + 16'(r_err) + 16'(r_drop);
        end
    end

    assign frame_cnt = r_frame_cnt;
    assign err_cnt   = r_err_cnt;
`endif

endmodule

// File: tb/tb_pmod_da4_rx.sv
// tb_pmod_da4_rx: table vectors, hand sequences and random frames
// checked against a queue-based model of the frame receiver.
`timescale 1ns/1ps
module tb_pmod_da4_rx;

    localparam int DW    = 12;
    localparam int DEPTH = 2;
    localparam int TW    = 8 + DW;
    localparam int HALF  = 5;
    localparam int GAP   = 20;

    logic clk = 1'b0;
    logic rst, sck, sdi, sync_n;
    logic [TW-1:0] tdata;
    logic tvalid, tready;
    logic frame_err, drop, busy;
`ifdef PMOD_DA4_RX_STATS_EN
    logic [15:0] frame_cnt, err_cnt;
`endif

    always #10 clk = ~clk;

    logic rdy_rand = 1'b0;
    logic rdy_fixed = 1'b1;
    logic rdy_rnd = 1'b0;
    assign tready = rdy_rand ? rdy_rnd : rdy_fixed;
    always @(posedge clk) rdy_rnd <= 1'($urandom_range(0, 1));

    pmod_da4_rx #(.DATA_W(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk           (clk),
        .rst           (rst),
        .sck           (sck),
        .sdi           (sdi),
        .sync_n        (sync_n),
        .m_axis_tdata  (tdata),
        .m_axis_tvalid (tvalid),
        .m_axis_tready (tready),
        .frame_err     (frame_err),
        .drop          (drop),
`ifdef PMOD_DA4_RX_STATS_EN
        .busy          (busy),
        .frame_cnt     (frame_cnt),
        .err_cnt       (err_cnt)
`else
        .busy          (busy)
`endif
    );

    int n_tests = 0;
    int n_fail = 0;
    int err_seen = 0;
    int drop_seen = 0;
    int exp_errs = 0;
    int exp_drops = 0;
    int m_frames = 0;
    int m_errs = 0;
    logic [TW-1:0] exp_q[$];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [TW-1:0] beat_of(input logic [31:0] f);
        logic [31:0] s;
        s = f >> (20 - DW);
        return s[TW-1:0];
    endfunction

    logic prev_err = 1'b0;
    logic prev_drop = 1'b0;
    logic prev_stall = 1'b0;
    logic [TW-1:0] prev_data = '0;

    // output monitor: scoreboard beats, pulse widths, stall stability
    always @(negedge clk) begin
        if (tvalid && tready) begin
            if (exp_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_beat: got 0x%0h, want none", tdata);
            end else begin
                check("beat", 32'(tdata), 32'(exp_q.pop_front()));
            end
        end
        if (prev_stall && tvalid)
            check("stall_hold", 32'(tdata), 32'(prev_data));
        if (frame_err) begin
            err_seen++;
            check("err_width", 32'(prev_err), 32'd0);
        end
        if (drop) begin
            drop_seen++;
            check("drop_width", 32'(prev_drop), 32'd0);
        end
        prev_err   = frame_err;
        prev_drop  = drop;
        prev_stall = tvalid && !tready;
        prev_data  = tdata;
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic b);
        sck = 1'b1;
        sdi = b;
        tick(HALF);
        sck = 1'b0;
        tick(HALF);
    endtask

    task automatic frame_bits(input logic [31:0] f, input int from,
                              input int n);
        for (int i = from; i < from + n; i++) begin
            if (i < 32) bit_out(f[31-i]);
            else bit_out(1'($urandom_range(0, 1)));
        end
    endtask

    task automatic drive_frame(input logic [31:0] f, input int n,
                               input bit simul);
        int idx;
        sync_n = 1'b0;
        tick(HALF);
        if (simul) begin
            frame_bits(f, 0, n - 1);
            idx = 32 - n;
            sck = 1'b1;
            sdi = f[idx];
            tick(HALF);
            sck = 1'b0;
            sync_n = 1'b1;
        end else begin
            frame_bits(f, 0, n);
            sync_n = 1'b1;
        end
        tick(GAP);
    endtask

    // model: a full frame is a beat unless nothing drains a full buffer
    task automatic send_frame(input logic [31:0] f, input int n);
        if (n >= 32) begin
            m_frames++;
            if (!rdy_rand && !rdy_fixed && exp_q.size() >= DEPTH) begin
                exp_drops++;
                m_errs++;
            end else begin
                exp_q.push_back(beat_of(f));
            end
        end else begin
            exp_errs++;
            m_errs++;
        end
        drive_frame(f, n, 1'b0);
    endtask

    task automatic drain(input string name);
        int i;
        i = 0;
        while (exp_q.size() != 0 && i < 500) begin
            @(posedge clk);
            i++;
        end
        tick(3);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    typedef struct {
        logic [31:0]   f;
        int            n;
        bit            simul;
        bit            has_beat;
        logic [TW-1:0] beat;
        int            err;
    } vec_t;

    vec_t tbl[8];

    initial begin
        logic [31:0] f;
        int n, r, e0, d0;

        tbl[0] = '{32'h032ABC00, 32, 1'b0, 1'b1, 20'h32ABC, 0};
        tbl[1] = '{32'h0F5A5A5A, 36, 1'b0, 1'b1, 20'hF5A5A, 0};
        tbl[2] = '{32'h8123456F, 31, 1'b0, 1'b0, 20'h00000, 1};
        tbl[3] = '{32'h00000000, 0,  1'b0, 1'b0, 20'h00000, 1};
        tbl[4] = '{32'hA4FEDCBA, 32, 1'b1, 1'b1, 20'h4FEDC, 0};
        tbl[5] = '{32'hF3FFFFFF, 32, 1'b0, 1'b1, 20'h3FFFF, 0};
        tbl[6] = '{32'h00000000, 40, 1'b0, 1'b1, 20'h00000, 0};
        tbl[7] = '{32'h12345678, 33, 1'b1, 1'b1, 20'h23456, 0};

        rst = 1'b1;
        sck = 1'b0;
        sdi = 1'b0;
        sync_n = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_tvalid", 32'(tvalid), 32'd0);
        check("rst_tdata", 32'(tdata), 32'd0);
        check("rst_err", 32'(frame_err), 32'd0);
        check("rst_drop", 32'(drop), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
`ifdef PMOD_DA4_RX_STATS_EN
        check("rst_fcnt", 32'(frame_cnt), 32'd0);
        check("rst_ecnt", 32'(err_cnt), 32'd0);
`endif
        @(posedge clk);
        #1 rst = 1'b0;
        tick(GAP);

        // first frame: valid exactly 4 cycles after the 32nd fall
        f = 32'h032ABC00;
        exp_q.push_back(beat_of(f));
        m_frames++;
        sync_n = 1'b0;
        tick(HALF);
        frame_bits(f, 0, 31);
        check("busy_shift", 32'(busy), 32'd1);
        sck = 1'b1;
        sdi = f[0];
        tick(HALF);
        sck = 1'b0;
        repeat (4) @(negedge clk);
        check("lat_early", 32'(tvalid), 32'd0);
        @(negedge clk);
        check("lat_valid", 32'(tvalid), 32'd1);
        check("lat_data", 32'(tdata), 32'h32ABC);
        tick(HALF);
        sync_n = 1'b1;
        tick(GAP);
        drain("first_drained");
        check("first_noerr", 32'(err_seen), 32'd0);

        // abort after 20 bits: frame_err 4 cycles after the rise
        exp_errs++;
        m_errs++;
        sync_n = 1'b0;
        tick(HALF);
        frame_bits(32'hDEADBEEF, 0, 20);
        sync_n = 1'b1;
        repeat (4) @(negedge clk);
        check("abort_early", 32'(frame_err), 32'd0);
        @(negedge clk);
        check("abort_err", 32'(frame_err), 32'd1);
        @(negedge clk);
        check("abort_clear", 32'(frame_err), 32'd0);
        tick(GAP);
        check("abort_novalid", 32'(tvalid), 32'd0);
        send_frame(32'h0170FFF0, 32);
        drain("after_abort");
        check("abort_errs", 32'(err_seen), 32'(exp_errs));

        for (int k = 0; k < 8; k++) begin
            e0 = err_seen;
            if (tbl[k].has_beat) exp_q.push_back(tbl[k].beat);
            if (tbl[k].n >= 32) m_frames++;
            m_errs += tbl[k].err;
            exp_errs += tbl[k].err;
            drive_frame(tbl[k].f, tbl[k].n, tbl[k].simul);
            drain($sformatf("vec%0d_beat", k));
            check($sformatf("vec%0d_err", k), 32'(err_seen - e0),
                  32'(tbl[k].err));
        end

        // backpressure: third frame into a full buffer is dropped
        d0 = drop_seen;
        rdy_fixed = 1'b0;
        for (int d = 1; d <= 3; d++)
            send_frame(32'h03000000 | (32'(d) << 8), 32);
        check("drop_count", 32'(drop_seen - d0), 32'd1);
        check("drop_hold_valid", 32'(tvalid), 32'd1);
        check("drop_head", 32'(tdata), 32'h30001);
        rdy_fixed = 1'b1;
        drain("drop_drained");
        @(negedge clk);
        check("drop_empty", 32'(tvalid), 32'd0);

        // reset mid-frame with sync_n held low: silent abandon
        e0 = err_seen;
        f = 32'h03555500;
        sync_n = 1'b0;
        tick(HALF);
        frame_bits(f, 0, 10);
        rst = 1'b1;
        tick(1);
        check("midrst_busy", 32'(busy), 32'd0);
        rst = 1'b0;
        m_frames = 0;
        m_errs = 0;
        frame_bits(f, 10, 22);
        sync_n = 1'b1;
        tick(GAP);
        check("midrst_noerr", 32'(err_seen - e0), 32'd0);
        check("midrst_novalid", 32'(tvalid), 32'd0);
        send_frame(32'h02123400, 32);
        drain("midrst_next");

        // randomized frames with random backpressure
        rdy_rand = 1'b1;
        for (int k = 0; k < 40; k++) begin
            f = $urandom;
            r = $urandom_range(0, 9);
            if (r < 7) n = 32;
            else if (r < 8) n = $urandom_range(0, 31);
            else n = $urandom_range(33, 40);
            send_frame(f, n);
        end
        rdy_rand = 1'b0;
        rdy_fixed = 1'b1;
        drain("rand_drained");
        check("rand_errs", 32'(err_seen), 32'(exp_errs));
        check("rand_drops", 32'(drop_seen), 32'(exp_drops));

`ifdef PMOD_DA4_RX_STATS_EN
        check("stat_frames", 32'(frame_cnt), 32'(m_frames & 16'hFFFF));
        check("stat_errs", 32'(err_cnt), 32'(m_errs & 16'hFFFF));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(GAP);
        rdy_fixed = 1'b0;
        for (int d = 1; d <= 3; d++)
            send_frame(32'h03000000 | (32'(d) << 8), 32);
        send_frame(32'h0FFFFFFF, 12);
        rdy_fixed = 1'b1;
        drain("stat_drain");
        send_frame(32'h00ABC000, 32);
        drain("stat_last");
        check("stat_fcnt4", 32'(frame_cnt), 32'd4);
        check("stat_ecnt2", 32'(err_cnt), 32'd2);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
